// File: rtl/fetch_queue.sv
`default_nettype none
//==============================================================================
// Module      : fetch_queue
// Description : Fetch stage. It owns the PC and issues one icache read per
//               cycle into a DEPTH-entry FIFO of {instr, index} entries that
//               feeds Decode over a valid/ready handshake.
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_queue #(
    parameter int                INSTR_W     = 16,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_INDEX = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_index,
    input  logic [INSTR_W-1:0]         mem_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_index,
    input  logic [ADDR_W-1:0]          redirect_delta,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_index,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_lvl_w = $clog2(DEPTH+1);
    localparam logic [c_lvl_w:0]   c_depth = (c_lvl_w+1)'(DEPTH);

    logic [ADDR_W-1:0]  r_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_index;
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [ADDR_W-1:0]  r_index_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_lvl_w-1:0] r_level;

    logic               w_pop;
    logic               w_push;
    logic [c_lvl_w:0]   w_occupancy;

    // Occupancy counts the read in flight so a push can never hit a full queue.
    assign w_pop       = out_valid & out_ready;
    assign w_push      = r_inflight & ~redirect;
    assign w_occupancy = {1'b0, r_level} + (c_lvl_w+1)'(r_inflight)
                         - (c_lvl_w+1)'(w_pop);

    // Reset gates the strobe directly so it drops between edges as well.
    assign mem_req   = enable & ~redirect & ~reset & (w_occupancy < c_depth);
    assign mem_index = r_pc;
    assign out_valid = (r_level != '0) & ~redirect;
    assign out_instr = r_instr_mem[r_head];
    assign out_index = r_index_mem[r_head];
    assign level     = r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc             <= RESET_INDEX;
            r_inflight       <= 1'b0;
            r_inflight_index <= '0;
            r_head           <= '0;
            r_tail           <= '0;
            r_level          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_index_mem[i] <= '0;
            end
        end else if (redirect) begin
            // Flush drops both any pop and the response landing this cycle.
            r_pc       <= redirect_index + redirect_delta;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_level    <= '0;
        end else begin
            r_inflight <= mem_req;
            if (mem_req) begin
                r_pc             <= r_pc + ADDR_W'(1);
                r_inflight_index <= r_pc;
            end
            if (w_push) begin
                r_instr_mem[r_tail] <= mem_data;
                r_index_mem[r_tail] <= r_inflight_index;
                r_tail              <= r_tail + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            r_level <= r_level + c_lvl_w'(w_push) - c_lvl_w'(w_pop);
        end
    end

endmodule
`default_nettype wire
